// File: rtl/laser500_pkg.sv
// Shared constants, request struct, FSM states and address mapping for the
// laser500 RAM upload path.
package laser500_pkg;

  localparam logic [7:0]  UPL_IDX_RAM     = 8'd0;
  localparam logic [7:0]  UPL_IDX_PRG     = 8'd1;
  localparam logic [7:0]  UPL_FILL        = 8'hFF;
  localparam logic [24:0] BASIC_BASE_ADDR = 25'h8995;

  typedef enum logic [1:0] {IDLE, ISSUE, WAITQ, CAPTURE} upl_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  idx;
  } upl_req_t;

  // BASIC uploads are offset into the program area; callers truncate to ADDR_W.
  function automatic logic [24:0] upl_map_addr(input logic [7:0]  index,
                                               input logic [24:0] addr,
                                               input logic [24:0] base = BASIC_BASE_ADDR);
    return (index == UPL_IDX_PRG) ? addr + base : addr;
  endfunction

  function automatic logic upl_idx_ok(input logic [7:0] index);
    return (index == UPL_IDX_RAM) || (index == UPL_IDX_PRG);
  endfunction

endpackage

// File: rtl/ram_uploader_if.sv
// Host ioctl upload handshake plus the RAM read port driven by the uploader.
interface ram_uploader_if #(parameter int ADDR_W = 18);
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_index;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_q;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, mem_q,
    output ioctl_din, ioctl_wait, mem_addr, mem_rd
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, mem_q,
    input  ioctl_din, ioctl_wait, mem_addr, mem_rd
  );
endinterface

// File: rtl/ram_uploader.sv
// Serves host upload reads from system RAM (index 0 raw, index 1 BASIC area).
// Define UPLOAD_CHECKSUM_EN to keep a running mod-256 sum of delivered bytes.
module ram_uploader
  import laser500_pkg::*;
#(
  parameter int          ADDR_W     = 18,
  parameter int          RD_LATENCY = 1,
  parameter logic [24:0] BASIC_BASE = BASIC_BASE_ADDR
) (
  input  logic           clk,
  input  logic           reset,
  ram_uploader_if.slave  bus,
  output logic           upl_active,
  output logic [7:0]     chksum
);

  upl_state_t state;
  upl_req_t   pend, req;
  logic       pend_vld, req_vld;
  logic [1:0] lat_cnt;

  // A queued request takes precedence over a fresh strobe.
  assign req_vld = pend_vld | bus.ioctl_rd;
  assign req     = pend_vld ? pend : upl_req_t'{addr: bus.ioctl_addr, idx: bus.ioctl_index};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pend           <= '0;
      pend_vld       <= 1'b0;
      lat_cnt        <= '0;
      upl_active     <= 1'b0;
      bus.ioctl_din  <= 8'h00;
      bus.ioctl_wait <= 1'b0;
      bus.mem_rd     <= 1'b0;
      bus.mem_addr   <= '0;
    end else begin
      upl_active <= bus.ioctl_upload;
      bus.mem_rd <= 1'b0;
      if (!bus.ioctl_upload) begin
        state          <= IDLE;
        bus.ioctl_wait <= 1'b0;
        pend_vld       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bus.ioctl_wait <= req_vld;
            pend_vld       <= 1'b0;
            if (req_vld) begin
              if (upl_idx_ok(req.idx)) begin
                state        <= ISSUE;
                bus.mem_rd   <= 1'b1;
                bus.mem_addr <= ADDR_W'(upl_map_addr(req.idx, req.addr, BASIC_BASE));
              end else begin
                bus.ioctl_din <= UPL_FILL;
              end
            end
          end
          ISSUE: begin
            lat_cnt <= 2'(RD_LATENCY - 1);
            state   <= (RD_LATENCY == 1) ? CAPTURE : WAITQ;
          end
          WAITQ: begin
            lat_cnt <= lat_cnt - 2'd1;
            if (lat_cnt == 2'd1) state <= CAPTURE;
          end
          CAPTURE: begin
            bus.ioctl_din  <= bus.mem_q;
            bus.ioctl_wait <= 1'b0;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
        // Strobes that can't be taken now queue one deep; a later one overwrites.
        if (bus.ioctl_rd && (state != IDLE || pend_vld)) begin
          pend     <= upl_req_t'{addr: bus.ioctl_addr, idx: bus.ioctl_index};
          pend_vld <= 1'b1;
        end
      end
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       upl_rise, ld_cap, ld_fill;

  assign upl_rise = bus.ioctl_upload & ~upl_active;
  assign ld_cap   = bus.ioctl_upload && (state == CAPTURE);
  assign ld_fill  = bus.ioctl_upload && (state == IDLE) && req_vld && !upl_idx_ok(req.idx);

  always_ff @(posedge clk) begin
    if (reset)         sum_q <= 8'h00;
    else if (upl_rise) sum_q <= ld_fill ? UPL_FILL : 8'h00;
    else if (ld_cap)   sum_q <= sum_q + bus.mem_q;
    else if (ld_fill)  sum_q <= sum_q + UPL_FILL;
  end

  assign chksum = sum_q;
`else
  assign chksum = 8'h00;
`endif

endmodule

// File: tb/tb_ram_uploader.sv
// Directed bench: one uploader at RD_LATENCY=1, one at RD_LATENCY=3.
module tb_ram_uploader;

  logic       clk, reset;
  logic       upl1, upl3;
  logic [7:0] sum1, sum3;
  int         checks, errors;

  logic [7:0] ram [0:262143];
  logic [7:0] d3 [3];

`ifdef UPLOAD_CHECKSUM_EN
  localparam logic [7:0] EXP_SUM = 8'h20;
`else
  localparam logic [7:0] EXP_SUM = 8'h00;
`endif

  ram_uploader_if #(.ADDR_W(18)) b1();
  ram_uploader_if #(.ADDR_W(18)) b3();

  ram_uploader #(.ADDR_W(18), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .upl_active(upl1), .chksum(sum1));
  ram_uploader #(.ADDR_W(18), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3), .upl_active(upl3), .chksum(sum3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: 1-cycle registered and 3-stage pipelined
  always @(posedge clk) if (b1.mem_rd) b1.mem_q <= ram[b1.mem_addr];
  always @(posedge clk) begin
    if (b3.mem_rd) d3[0] <= ram[b3.mem_addr];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign b3.mem_q = d3[2];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe1(input logic [24:0] a, input logic [7:0] idx);
    b1.ioctl_addr = a; b1.ioctl_index = idx; b1.ioctl_rd = 1'b1;
    tick();
    b1.ioctl_rd = 1'b0;
  endtask

  task automatic strobe3(input logic [24:0] a, input logic [7:0] idx);
    b3.ioctl_addr = a; b3.ioctl_index = idx; b3.ioctl_rd = 1'b1;
    tick();
    b3.ioctl_rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (b1.ioctl_din !== 8'h00) begin errors++; $display("FAIL rst_din got %h exp 00", b1.ioctl_din); end
    checks++; if (b1.ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_wait got %b exp 0", b1.ioctl_wait); end
    checks++; if (b1.mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd got %b exp 0", b1.mem_rd); end
    checks++; if (b1.mem_addr !== 18'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", b1.mem_addr); end
    checks++; if (upl1 !== 1'b0) begin errors++; $display("FAIL rst_upl_active got %b exp 0", upl1); end
    checks++; if (sum1 !== 8'h00) begin errors++; $display("FAIL rst_chksum got %h exp 00", sum1); end
    reset = 1'b0;
  endtask

  task automatic test_ram_read();
    b1.ioctl_upload = 1'b1;
    tick();
    checks++; if (upl1 !== 1'b1) begin errors++; $display("FAIL upl_active_follow got %b exp 1", upl1); end
    strobe1(25'h0123, 8'd0);
    checks++; if (b1.mem_rd !== 1'b1 || b1.mem_addr !== 18'h0123) begin errors++; $display("FAIL ram_issue rd=%b addr=%h exp rd=1 addr=00123", b1.mem_rd, b1.mem_addr); end
    checks++; if (b1.ioctl_wait !== 1'b1) begin errors++; $display("FAIL ram_wait_c1 got %b exp 1", b1.ioctl_wait); end
    tick();
    checks++; if (b1.mem_rd !== 1'b0 || b1.ioctl_wait !== 1'b1) begin errors++; $display("FAIL ram_c2 rd=%b wait=%b exp rd=0 wait=1", b1.mem_rd, b1.ioctl_wait); end
    tick();
    checks++; if (b1.ioctl_din !== 8'h5A || b1.ioctl_wait !== 1'b0) begin errors++; $display("FAIL ram_data din=%h wait=%b exp din=5a wait=0", b1.ioctl_din, b1.ioctl_wait); end
  endtask

  task automatic test_basic_map();
    strobe1(25'h0, 8'd1);
    checks++; if (b1.mem_addr !== 18'h08995) begin errors++; $display("FAIL prg_base got %h exp 08995", b1.mem_addr); end
    tick(); tick();
    checks++; if (b1.ioctl_din !== 8'h11) begin errors++; $display("FAIL prg_base_din got %h exp 11", b1.ioctl_din); end
    strobe1(25'h3FFFF, 8'd1);
    checks++; if (b1.mem_addr !== 18'h08994) begin errors++; $display("FAIL prg_wrap got %h exp 08994", b1.mem_addr); end
    tick(); tick();
    checks++; if (b1.ioctl_din !== 8'h22) begin errors++; $display("FAIL prg_wrap_din got %h exp 22", b1.ioctl_din); end
  endtask

  task automatic test_fill();
    strobe1(25'h0123, 8'd5);
    checks++; if (b1.mem_rd !== 1'b0 || b1.ioctl_wait !== 1'b1 || b1.ioctl_din !== 8'hFF) begin errors++; $display("FAIL fill_c1 rd=%b wait=%b din=%h exp rd=0 wait=1 din=ff", b1.mem_rd, b1.ioctl_wait, b1.ioctl_din); end
    tick();
    checks++; if (b1.mem_rd !== 1'b0 || b1.ioctl_wait !== 1'b0) begin errors++; $display("FAIL fill_c2 rd=%b wait=%b exp rd=0 wait=0", b1.mem_rd, b1.ioctl_wait); end
  endtask

  task automatic test_back_to_back();
    int ta, tb;
    ta = -1; tb = -1;
    b3.ioctl_upload = 1'b1;
    tick();
    strobe3(25'h10, 8'd0);
    strobe3(25'h11, 8'd0);
    for (int k = 2; k <= 14; k++) begin
      tick();
      if (ta < 0 && b3.ioctl_din === 8'hAA) ta = k;
      if (tb < 0 && b3.ioctl_din === 8'hBB) tb = k;
    end
    checks++; if (ta != 4) begin errors++; $display("FAIL b2b_first_cycle got %0d exp 4", ta); end
    checks++; if (tb != 9) begin errors++; $display("FAIL b2b_second_cycle got %0d exp 9", tb); end
  endtask

  task automatic test_abort();
    strobe3(25'h10, 8'd0);
    tick();
    b3.ioctl_upload = 1'b0;
    tick();
    checks++; if (b3.mem_rd !== 1'b0 || b3.ioctl_wait !== 1'b0) begin errors++; $display("FAIL abort_outputs rd=%b wait=%b exp rd=0 wait=0", b3.mem_rd, b3.ioctl_wait); end
    checks++; if (b3.ioctl_din !== 8'hBB) begin errors++; $display("FAIL abort_din_hold got %h exp bb", b3.ioctl_din); end
    tick(); tick(); tick(); tick();
    checks++; if (b3.ioctl_din !== 8'hBB) begin errors++; $display("FAIL abort_no_late_capture got %h exp bb", b3.ioctl_din); end
    checks++; if (upl3 !== 1'b0) begin errors++; $display("FAIL abort_upl_active got %b exp 0", upl3); end
  endtask

  task automatic test_reset_mid();
    strobe1(25'h0123, 8'd0);
    reset = 1'b1;
    tick();
    checks++; if (b1.ioctl_din !== 8'h00 || b1.ioctl_wait !== 1'b0 || b1.mem_rd !== 1'b0) begin errors++; $display("FAIL midrst_a din=%h wait=%b rd=%b exp 00/0/0", b1.ioctl_din, b1.ioctl_wait, b1.mem_rd); end
    checks++; if (b1.mem_addr !== 18'h0 || upl1 !== 1'b0) begin errors++; $display("FAIL midrst_b addr=%h upl=%b exp 0/0", b1.mem_addr, upl1); end
    reset = 1'b0;
    tick(); tick(); tick();
    checks++; if (b1.ioctl_din !== 8'h00) begin errors++; $display("FAIL midrst_no_resume got %h exp 00", b1.ioctl_din); end
  endtask

  task automatic test_checksum();
    strobe1(25'h200, 8'd0); tick(); tick();
    strobe1(25'h201, 8'd0); tick(); tick();
    strobe1(25'h202, 8'd0); tick(); tick();
    checks++; if (b1.ioctl_din !== 8'h10) begin errors++; $display("FAIL chk_last_din got %h exp 10", b1.ioctl_din); end
    checks++; if (sum1 !== EXP_SUM) begin errors++; $display("FAIL chk_sum got %h exp %h", sum1, EXP_SUM); end
    b1.ioctl_upload = 1'b0;
    tick(); tick();
    b1.ioctl_upload = 1'b1;
    tick();
    checks++; if (sum1 !== 8'h00) begin errors++; $display("FAIL chk_clear got %h exp 00", sum1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    b1.ioctl_upload = 1'b0; b1.ioctl_rd = 1'b0; b1.ioctl_addr = '0; b1.ioctl_index = '0;
    b3.ioctl_upload = 1'b0; b3.ioctl_rd = 1'b0; b3.ioctl_addr = '0; b3.ioctl_index = '0;
    b1.mem_q = 8'h00;
    d3[0] = 8'h00; d3[1] = 8'h00; d3[2] = 8'h00;
    ram[18'h00123] = 8'h5A;
    ram[18'h08995] = 8'h11;
    ram[18'h08994] = 8'h22;
    ram[18'h00010] = 8'hAA;
    ram[18'h00011] = 8'hBB;
    ram[18'h00200] = 8'h80;
    ram[18'h00201] = 8'h90;
    ram[18'h00202] = 8'h10;
    test_reset();
    test_ram_read();
    test_basic_map();
    test_fill();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_checksum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
